// File: rtl/bumpy_state_ctrl_if.sv
// Handshake bundle between the keyboard/collision logic and the Bumpy state controller.
// The master side drives frame strobe, keys and hits; the controller answers with state and lives.
interface bumpy_state_ctrl_if;
    logic       startOfFrame;
    logic       game_start;
    logic       key_left;
    logic       key_right;
    logic       key_up;
    logic       key_down;
    logic       hit_wall_left;
    logic       hit_wall_right;
    logic       hit_wall_top;
    logic       hit_hazard;
    logic [3:0] state;
    logic [1:0] lives_left;
    logic       dead_pulse;
    logic       game_over;

    modport master (
        output startOfFrame, game_start,
        output key_left, key_right, key_up, key_down,
        output hit_wall_left, hit_wall_right, hit_wall_top, hit_hazard,
        input  state, lives_left, dead_pulse, game_over
    );

    modport slave (
        input  startOfFrame, game_start,
        input  key_left, key_right, key_up, key_down,
        input  hit_wall_left, hit_wall_right, hit_wall_top, hit_hazard,
        output state, lives_left, dead_pulse, game_over
    );
endinterface

// File: rtl/bumpy_state_ctrl.sv
// Per-frame motion state controller for Bumpy: one decision per startOfFrame from keys,
// latched collisions and game start, with timed bounce/die intervals and a lives counter.
module bumpy_state_ctrl #(
    parameter int BOUNCE_FRAMES = 8,
    parameter int DIE_FRAMES    = 60,
    parameter int LIVES         = 3
) (
    input  logic              clk,
    input  logic              resetN,
    bumpy_state_ctrl_if.slave bus
);
    localparam logic [3:0] S_RESET = 4'd0;
    localparam logic [3:0] S_IDLE  = 4'd1;
    localparam logic [3:0] S_LEFT  = 4'd2;
    localparam logic [3:0] S_RIGHT = 4'd3;
    localparam logic [3:0] S_DOWN  = 4'd4;
    localparam logic [3:0] S_UP    = 4'd5;
    localparam logic [3:0] S_DIE   = 4'd6;
    localparam logic [3:0] S_BNC_L = 4'd7;
    localparam logic [3:0] S_BNC_R = 4'd8;
    localparam logic [3:0] S_BNC_T = 4'd9;

    localparam logic [7:0] BOUNCE_LOAD = 8'(BOUNCE_FRAMES - 1);
    localparam logic [7:0] DIE_LOAD    = 8'(DIE_FRAMES - 1);
    localparam logic [1:0] LIVES_LOAD  = 2'(LIVES);

    typedef struct packed {
        logic hazard;
        logic top;
        logic right;
        logic left;
    } hits_t;

    logic [3:0] state_r, state_nx;
    logic [7:0] cnt_r, cnt_nx;
    logic [1:0] lives_r, lives_nx;
    logic       dead_r, dead_nx;
    logic       over_r, over_nx;
    hits_t      flags_r, hits_live, hits_eff;
    logic       any_wall, in_bounce;
    logic [3:0] wall_state, key_state;

    // Horizontal keys win over vertical; opposing keys cancel to idle.
    function automatic logic [3:0] key_target(input logic l, input logic r,
                                              input logic u, input logic d);
        if (l ^ r) return l ? S_LEFT : S_RIGHT;
        if (l & r) return S_IDLE;
        if (u ^ d) return d ? S_DOWN : S_UP;
        return S_IDLE;
    endfunction

    // A decision sees the sticky flags plus any hit arriving in the same cycle.
    assign hits_live = {bus.hit_hazard, bus.hit_wall_top, bus.hit_wall_right, bus.hit_wall_left};
    assign hits_eff  = hits_t'(flags_r | hits_live);
    assign any_wall  = hits_eff.left | hits_eff.right | hits_eff.top;
    assign in_bounce = (state_r >= S_BNC_L);
    assign key_state = key_target(bus.key_left, bus.key_right, bus.key_up, bus.key_down);

    always_comb begin
        wall_state = S_BNC_T;
        if (hits_eff.left)       wall_state = S_BNC_L;
        else if (hits_eff.right) wall_state = S_BNC_R;
    end

    always_comb begin
        state_nx = state_r;
        cnt_nx   = cnt_r;
        lives_nx = lives_r;
        over_nx  = over_r;
        dead_nx  = 1'b0;
        if (bus.startOfFrame) begin
            case (state_r)
                S_RESET: begin
                    if (bus.game_start) begin
                        state_nx = S_IDLE;
                        lives_nx = LIVES_LOAD;
                        over_nx  = 1'b0;
                    end
                end
                S_IDLE, S_LEFT, S_RIGHT, S_DOWN, S_UP,
                S_BNC_L, S_BNC_R, S_BNC_T: begin
                    if (hits_eff.hazard) begin
                        state_nx = S_DIE;
                        cnt_nx   = DIE_LOAD;
                        lives_nx = (lives_r == 2'd0) ? 2'd0 : lives_r - 2'd1;
                        dead_nx  = 1'b1;
                    end else if (any_wall) begin
                        state_nx = wall_state;
                        cnt_nx   = BOUNCE_LOAD;
                    end else if (!in_bounce || cnt_r == 8'd0) begin
                        state_nx = key_state;
                    end else begin
                        cnt_nx = cnt_r - 8'd1;
                    end
                end
                S_DIE: begin
                    if (cnt_r != 8'd0) begin
                        cnt_nx = cnt_r - 8'd1;
                    end else if (lives_r == 2'd0) begin
                        state_nx = S_RESET;
                        over_nx  = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
                default: state_nx = S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r <= S_RESET;
            cnt_r   <= 8'd0;
            lives_r <= LIVES_LOAD;
            dead_r  <= 1'b0;
            over_r  <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            lives_r <= lives_nx;
            dead_r  <= dead_nx;
            over_r  <= over_nx;
        end
    end

    // Every decision consumes the flags, including a hit landing in that very cycle.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)               flags_r <= '0;
        else if (bus.startOfFrame) flags_r <= '0;
        else                       flags_r <= hits_eff;
    end

    assign bus.state      = state_r;
    assign bus.lives_left = lives_r;
    assign bus.dead_pulse = dead_r;
    assign bus.game_over  = over_r;
endmodule

// File: tb/tb_bumpy_state_ctrl.sv
// Bench for bumpy_state_ctrl: directed plan with literal checks, then random frames
// compared every cycle against a frame-level behavioural model.
module tb_bumpy_state_ctrl;
    localparam int BF = 8;
    localparam int DF = 60;
    localparam int NL = 3;

    logic clk = 1'b0;
    logic resetN = 1'b1;
    always #5 clk = ~clk;

    bumpy_state_ctrl_if bus();

    bumpy_state_ctrl #(.BOUNCE_FRAMES(BF), .DIE_FRAMES(DF), .LIVES(NL)) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Model: state number, frames already spent in a timed interval, lives, flags.
    int m_state, m_held, m_lives;
    bit m_over, m_dead;
    bit [3:0] m_flags;
    int n_state, n_held, n_lives;
    bit n_over, n_dead;
    bit [3:0] n_flags;

    function automatic int steer(bit l, bit r, bit u, bit d);
        int h, v;
        h = int'(r) - int'(l);
        v = int'(d) - int'(u);
        if (l | r) return (h < 0) ? 2 : ((h > 0) ? 3 : 1);
        return (v > 0) ? 4 : ((v < 0) ? 5 : 1);
    endfunction

    task automatic model_reset();
        m_state = 0; m_held = 0; m_lives = NL; m_over = 0; m_dead = 0; m_flags = '0;
    endtask

    task automatic model_step();
        bit [3:0] live, eff;
        live = {bus.hit_hazard, bus.hit_wall_top, bus.hit_wall_right, bus.hit_wall_left};
        eff = m_flags | live;
        n_state = m_state; n_held = m_held; n_lives = m_lives; n_over = m_over; n_dead = 0;
        n_flags = bus.startOfFrame ? 4'b0 : eff;
        if (!resetN) begin
            n_state = 0; n_held = 0; n_lives = NL; n_over = 0; n_flags = '0;
        end else if (bus.startOfFrame) begin
            if (m_state == 0) begin
                if (bus.game_start) begin n_state = 1; n_lives = NL; n_over = 0; end
            end else if (m_state == 6) begin
                if (m_held < DF) n_held = m_held + 1;
                else if (m_lives == 0) begin n_state = 0; n_over = 1; end
                else n_state = 1;
            end else if (eff[3]) begin
                n_state = 6; n_held = 1; n_dead = 1;
                n_lives = (m_lives > 0) ? m_lives - 1 : 0;
            end else if (eff[2:0] != 0) begin
                n_state = eff[0] ? 7 : (eff[1] ? 8 : 9);
                n_held = 1;
            end else if (m_state < 7 || m_held >= BF) begin
                n_state = steer(bus.key_left, bus.key_right, bus.key_up, bus.key_down);
            end else begin
                n_held = m_held + 1;
            end
        end
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        m_state = n_state; m_held = n_held; m_lives = n_lives;
        m_over = n_over; m_dead = n_dead; m_flags = n_flags;
        #2;
    endtask

    always @(negedge clk) begin
        n_checks++;
        if (int'(bus.state) != m_state || int'(bus.lives_left) != m_lives ||
            bus.dead_pulse != m_dead || bus.game_over != m_over) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t: state %0d want %0d, lives %0d want %0d, dead %0d want %0d, over %0d want %0d",
                     $time, bus.state, m_state, bus.lives_left, m_lives,
                     bus.dead_pulse, m_dead, bus.game_over, m_over);
        end
    end

    task automatic expect_eq(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_hits(bit [3:0] h);
        {bus.hit_hazard, bus.hit_wall_top, bus.hit_wall_right, bus.hit_wall_left} = h;
    endtask

    task automatic set_keys(bit l, bit r, bit u, bit d);
        bus.key_left = l; bus.key_right = r; bus.key_up = u; bus.key_down = d;
    endtask

    // Three quiet cycles (hits pulsed in the second), then the decision cycle.
    task automatic frame(bit [3:0] hits = 4'b0);
        bus.startOfFrame = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_hits((i == 1) ? hits : 4'b0);
            cyc();
        end
        set_hits(4'b0);
        bus.startOfFrame = 1'b1;
        cyc();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic frames(int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic reset_pulse();
        resetN = 1'b0;
        model_reset();
        cyc();
        cyc();
        resetN = 1'b1;
    endtask

    function automatic bit chance(int n);
        return ($urandom % n) == 0;
    endfunction

    initial begin
        bus.startOfFrame = 0; bus.game_start = 0;
        set_keys(0, 0, 0, 0);
        set_hits(4'b0);
        model_reset();
        #1 resetN = 1'b0;
        cyc();
        cyc();
        expect_eq("reset_state", int'(bus.state), 0);
        expect_eq("reset_lives", int'(bus.lives_left), 3);
        expect_eq("reset_over", int'(bus.game_over), 0);
        expect_eq("reset_dead", int'(bus.dead_pulse), 0);
        resetN = 1'b1;

        bus.game_start = 1;
        frame();
        bus.game_start = 0;
        expect_eq("start_state", int'(bus.state), 1);
        expect_eq("start_lives", int'(bus.lives_left), 3);

        set_keys(1, 0, 1, 0);
        frame();
        expect_eq("left_over_up", int'(bus.state), 2);
        set_keys(1, 1, 1, 0);
        frame();
        expect_eq("left_right_cancel", int'(bus.state), 1);

        set_keys(0, 1, 0, 0);
        frame();
        expect_eq("right", int'(bus.state), 3);
        frame(4'b0001);
        expect_eq("bounce_left_entry", int'(bus.state), 7);
        frames(BF - 1);
        expect_eq("bounce_left_last", int'(bus.state), 7);
        frame();
        expect_eq("bounce_exit_right", int'(bus.state), 3);

        frame(4'b1100);
        expect_eq("die_entry", int'(bus.state), 6);
        expect_eq("die_pulse", int'(bus.dead_pulse), 1);
        expect_eq("die_lives", int'(bus.lives_left), 2);
        cyc();
        expect_eq("die_pulse_one_clk", int'(bus.dead_pulse), 0);
        frames(DF - 1);
        expect_eq("die_last", int'(bus.state), 6);
        frame();
        expect_eq("die_exit_idle", int'(bus.state), 1);

        frame(4'b1000);
        frames(DF);
        expect_eq("second_death_lives", int'(bus.lives_left), 1);
        frame(4'b1000);
        frames(DF);
        expect_eq("game_over_state", int'(bus.state), 0);
        expect_eq("game_over_flag", int'(bus.game_over), 1);
        expect_eq("game_over_lives", int'(bus.lives_left), 0);
        bus.game_start = 1;
        frame();
        bus.game_start = 0;
        expect_eq("restart_state", int'(bus.state), 1);
        expect_eq("restart_lives", int'(bus.lives_left), 3);
        expect_eq("restart_over", int'(bus.game_over), 0);

        frame(4'b0010);
        expect_eq("bounce_right_entry", int'(bus.state), 8);
        frames(3);
        set_hits(4'b0001);
        cyc();
        set_hits(4'b0000);
        resetN = 1'b0;
        model_reset();
        #1;
        expect_eq("async_reset_state", int'(bus.state), 0);
        cyc();
        resetN = 1'b1;
        bus.game_start = 1;
        frame();
        bus.game_start = 0;
        set_keys(0, 0, 0, 0);
        frame();
        expect_eq("no_stale_hit", int'(bus.state), 1);

        for (int f = 0; f < 600; f++) begin
            int gap;
            set_keys(chance(2), chance(2), chance(2), chance(2));
            gap = $urandom_range(0, 4);
            bus.startOfFrame = 0;
            for (int i = 0; i < gap; i++) begin
                set_hits({chance(60), chance(25), chance(25), chance(25)});
                cyc();
            end
            set_hits({chance(60), chance(25), chance(25), chance(25)});
            bus.game_start = chance(3);
            bus.startOfFrame = 1;
            cyc();
            bus.startOfFrame = 0;
            set_hits(4'b0);
            if (f % 150 == 77) reset_pulse();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
